// File: rtl/uart_pkg.sv
// Shared 8N1 framing constants and receiver state type for the UART receive path.
package uart_pkg;

  localparam int unsigned DataBits = 8;
  localparam int unsigned StopBits = 1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter with mid-bit (half) and end-of-bit (full) terminal-count flags.
module uart_baud_cnt #(
  parameter int unsigned ClksPerBit = 868
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic half_o,
  output logic full_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_o = (cnt_q == CntW'(ClksPerBit / 2 - 1));
  assign full_o = (cnt_q == CntW'(ClksPerBit - 1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a single-entry valid/ready output register,
// framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       rx_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  logic      rx_meta_q, rx_s, rx_q;
  rx_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       cnt_clr, half, full, deliver;

  uart_baud_cnt #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (cnt_clr),
    .half_o(half),
    .full_o(full)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    cnt_clr = 1'b0;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    data_d  = data_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        idx_d   = '0;
        // Only a high-to-low transition starts a frame; a line already low is ignored.
        if (en_i && rx_q && !rx_s) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (half) begin
          cnt_clr = 1'b1;
          idx_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (full) begin
          cnt_clr         = 1'b1;
          shift_d[idx_q]  = rx_s;
          idx_d           = idx_q + 3'd1;
          if (idx_q == 3'(DataBits - 1)) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (full) begin
          cnt_clr = 1'b1;
          state_d = StIdle;
          if (rx_s) begin
            deliver = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (!en_i) begin
      state_d = StIdle;
      cnt_clr = 1'b1;
      deliver = 1'b0;
      ferr_d  = 1'b0;
    end

    // A held byte is only replaced if the consumer takes it in the same cycle.
    if (deliver) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
      rx_q      <= 1'b1;
      state_q   <= StIdle;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s      <= rx_meta_q;
      rx_q      <= rx_s;
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit with a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned Cpb = 16;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       en_i    = 1'b1;
  logic       rx_i    = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o;

  int checks = 0;
  int errors = 0;

  uart_rx #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .rx_i       (rx_i),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int         valid_rises  = 0;
  int         valid_cycles = 0;
  int         ferr_cycles  = 0;
  int         ovr_cycles   = 0;
  int         stab_errs    = 0;
  int         rise_cyc     = 0;
  logic [7:0] last_data    = 8'h00;
  logic [7:0] data_prev    = 8'h00;
  logic       valid_prev   = 1'b0;

  always @(negedge clk_i) begin
    if (valid_o) valid_cycles <= valid_cycles + 1;
    if (valid_o && !valid_prev) begin
      valid_rises <= valid_rises + 1;
      rise_cyc    <= cyc;
      last_data   <= data_o;
    end
    if (valid_o && valid_prev && data_o !== data_prev) stab_errs <= stab_errs + 1;
    if (frame_err_o) ferr_cycles <= ferr_cycles + 1;
    if (overrun_o) ovr_cycles <= ovr_cycles + 1;
    valid_prev <= valid_o;
    data_prev  <= data_o;
  end

  int fall_cyc = 0;

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i     = 1'b0;
    fall_cyc = cyc;
    idle(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      idle(Cpb);
    end
    rx_i = stop_bit;
    idle(Cpb);
    rx_i = 1'b1;
  endtask

  task automatic test_reset;
    idle(3);
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h ferr=%b ovr=%b, expected all zero",
               valid_o, data_o, frame_err_o, overrun_o);
    end
    rst_ni = 1'b1;
    idle(5);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_valid: got %b expected 0", valid_o);
    end
  endtask

  task automatic test_single;
    int r0 = valid_rises, v0 = valid_cycles, f0 = ferr_cycles, o0 = ovr_cycles;
    int lat;
    ready_i = 1'b1;
    send_byte(8'hA5, 1'b1);
    idle(10);
    lat = rise_cyc - fall_cyc;
    checks++;
    if (last_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: got %h expected a5", last_data);
    end
    checks++;
    if (valid_rises - r0 != 1 || valid_cycles - v0 != 1) begin
      errors++;
      $display("FAIL single_valid_width: got rises=%0d cycles=%0d expected 1/1",
               valid_rises - r0, valid_cycles - v0);
    end
    checks++;
    if (ferr_cycles != f0 || ovr_cycles != o0) begin
      errors++;
      $display("FAIL single_no_errors: got ferr=%0d ovr=%0d expected 0/0",
               ferr_cycles - f0, ovr_cycles - o0);
    end
    checks++;
    if (lat < 154 || lat > 156) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles expected 155 +/- 1", lat);
    end
  endtask

  task automatic test_glitch;
    int r0 = valid_rises, f0 = ferr_cycles;
    rx_i = 1'b0;
    idle(3);
    rx_i = 1'b1;
    idle(40);
    checks++;
    if (valid_rises != r0 || ferr_cycles != f0) begin
      errors++;
      $display("FAIL glitch_reject: got rises=%0d ferr=%0d expected 0/0",
               valid_rises - r0, ferr_cycles - f0);
    end
  endtask

  task automatic test_frame_err;
    int r0 = valid_rises, f0 = ferr_cycles;
    send_byte(8'h3C, 1'b0);
    idle(20);
    checks++;
    if (ferr_cycles - f0 != 1) begin
      errors++;
      $display("FAIL frame_err_pulse: got %0d cycles expected 1", ferr_cycles - f0);
    end
    checks++;
    if (valid_rises != r0) begin
      errors++;
      $display("FAIL frame_err_no_valid: got %0d rises expected 0", valid_rises - r0);
    end
  endtask

  task automatic test_back_to_back;
    int r0 = valid_rises, o0 = ovr_cycles, s0 = stab_errs;
    ready_i = 1'b0;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h81, 1'b1);
    idle(10);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_held: got valid=%b data=%h expected 1/3c", valid_o, data_o);
    end
    checks++;
    if (ovr_cycles - o0 != 1 || valid_rises - r0 != 1) begin
      errors++;
      $display("FAIL b2b_overrun: got ovr=%0d rises=%0d expected 1/1",
               ovr_cycles - o0, valid_rises - r0);
    end
    checks++;
    if (stab_errs != s0) begin
      errors++;
      $display("FAIL b2b_stable: got %0d data changes while valid expected 0", stab_errs - s0);
    end
    ready_i = 1'b1;
    idle(1);
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_consume: got valid=%b data=%h expected 0/3c", valid_o, data_o);
    end
  endtask

  task automatic test_reset_mid_frame;
    int r0;
    ready_i = 1'b0;
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(5);
    r0   = valid_rises;
    rx_i = 1'b0;
    idle(Cpb);
    rx_i = 1'b1;
    idle(4 * Cpb + Cpb / 2);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b data=%h ferr=%b ovr=%b, expected all zero",
               valid_o, data_o, frame_err_o, overrun_o);
    end
    idle(4);
    rst_ni = 1'b1;
    idle(200);
    checks++;
    if (valid_rises != r0) begin
      errors++;
      $display("FAIL midreset_abandon: got %0d rises expected 0", valid_rises - r0);
    end
    send_byte(8'h5A, 1'b1);
    idle(10);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h5A) begin
      errors++;
      $display("FAIL midreset_resume: got valid=%b data=%h expected 1/5a", valid_o, data_o);
    end
    ready_i = 1'b1;
    idle(3);
  endtask

  task automatic test_enable;
    int r0 = valid_rises, f0 = ferr_cycles;
    en_i = 1'b0;
    send_byte(8'h11, 1'b1);
    idle(10);
    checks++;
    if (valid_rises != r0) begin
      errors++;
      $display("FAIL enable_off: got %0d rises expected 0", valid_rises - r0);
    end
    en_i = 1'b1;
    idle(5);
    send_byte(8'h22, 1'b1);
    idle(10);
    checks++;
    if (valid_rises - r0 != 1 || last_data !== 8'h22) begin
      errors++;
      $display("FAIL enable_on: got rises=%0d data=%h expected 1/22",
               valid_rises - r0, last_data);
    end
    // Drop enable during bit 3 of an all-ones byte: nothing may come out of it.
    r0   = valid_rises;
    rx_i = 1'b0;
    idle(Cpb);
    rx_i = 1'b1;
    idle(3 * Cpb + 4);
    en_i = 1'b0;
    idle(2);
    en_i = 1'b1;
    idle(8 * Cpb);
    checks++;
    if (valid_rises != r0 || ferr_cycles != f0) begin
      errors++;
      $display("FAIL enable_abort: got rises=%0d ferr=%0d expected 0/0",
               valid_rises - r0, ferr_cycles - f0);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b;
      logic       stop_ok;
      int         r0, f0, exp_rises, exp_ferr;
      b         = 8'($urandom_range(0, 255));
      stop_ok   = ($urandom_range(0, 3) != 0);
      r0        = valid_rises;
      f0        = ferr_cycles;
      // Reference: a good stop bit yields the byte, a bad one yields one error pulse.
      exp_rises = stop_ok ? 1 : 0;
      exp_ferr  = stop_ok ? 0 : 1;
      send_byte(b, stop_ok);
      idle(10 + int'($urandom_range(0, 20)));
      checks++;
      if (valid_rises - r0 != exp_rises || ferr_cycles - f0 != exp_ferr ||
          (stop_ok && last_data !== b)) begin
        errors++;
        $display("FAIL random_%0d: got rises=%0d ferr=%0d data=%h expected %0d/%0d/%h",
                 n, valid_rises - r0, ferr_cycles - f0, last_data, exp_rises, exp_ferr, b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
